collatz_seq_engine: RTL and testbench
=====================================

COLLATZ_SEQ_ENGINE -- requirements
Module: collatz_seq_engine

Interface
REQ-001 SHALL have parameter N_W, default 16, meaning width of start value and working register (>=4).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of iteration counter (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request; accepted in IDLE or DONE.
REQ-006 SHALL have port n_in  input  N_W  start value, sampled when start is accepted.
REQ-007 SHALL have port abort  input  1  forces return to IDLE.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  high while in DONE; results valid.
REQ-010 SHALL have port steps  output  CNT_W  iteration count.
REQ-011 SHALL have port status  output  2  00 ok, 01 zero input, 10 arithmetic overflow, 11 counter saturated.
REQ-012 SHALL have port peak  output  N_W  largest working value reached (only with COLLATZ_PEAK_EN).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy=(RUN), done=(DONE), both registered.
REQ-014 In IDLE or DONE, SHALL accept start: load n<=n_in, steps<=0, status<=00, peak<=n_in, go RUN next cycle; in DONE an accepted start clears done the next cycle.
REQ-015 SHALL ignore start while in RUN.
REQ-016 Each RUN cycle with n==1: go DONE, no step counted.
REQ-017 Each RUN cycle with n even and n!=0: n<=n>>1, steps<=steps+1.
REQ-018 Each RUN cycle with n odd and n!=1: n<=3n+1 computed at N_W+2 bits; if result >= 2^N_W, go DONE with status=10, n and steps unchanged; else load n, steps+1.
REQ-019 Each RUN cycle with n==0: go DONE with status=01, steps=0.
REQ-020 If a step would increment steps from all-ones, SHALL go DONE with status=11 and steps held at all-ones; value n is not updated.
REQ-021 Latency: done rises exactly steps+2 cycles after the accepted-start edge for status 00.
REQ-022 DONE SHALL hold steps, status, peak stable until next accepted start, abort, or reset.
REQ-023 abort SHALL take priority over start and any RUN step; next state IDLE, outputs steps/status/peak retain last values.
REQ-024 Simultaneous start and abort: abort wins; start is dropped.

Reset
REQ-025 rst_n low at a rising clk edge SHALL force IDLE, busy=0, done=0, steps=0, status=00, peak=0, n=0, regardless of state (including mid-RUN); rst_n has priority over abort and start.

Configuration
REQ-026 Macro COLLATZ_PEAK_EN defined: peak register and port present, peak<=max(peak, new n) on every loaded step.
REQ-027 Macro COLLATZ_PEAK_EN undefined: no peak register or port; all other behaviour identical.

Structure
REQ-028 Shared package collatz_pkg SHALL hold the FSM state enum and the status code constants (ST_OK, ST_ZERO, ST_OVF, ST_SAT).
REQ-029 SHALL use one combinational sub-module collatz_step (parameter N_W): in n, out next value and overflow flag.

Verification
REQ-030 N_W=16, n_in=6 -> done with steps=8, status=00, peak=16.
REQ-031 N_W=16, n_in=27 -> steps=111, status=00, peak=9232, done 113 cycles after start.
REQ-032 n_in=1 -> steps=0, status=00, done 2 cycles after start; n_in=0 -> steps=0, status=01.
REQ-033 N_W=8, n_in=27 -> status=10, steps=11 (overflow at 3*107+1=322).
REQ-034 N_W=16, CNT_W=4, n_in=27 -> status=11, steps=15.
REQ-035 rst_n low for 1 cycle mid-RUN (n_in=27, cycle 20) -> all outputs at reset values next cycle; abort mid-RUN -> IDLE, busy=0; start during RUN ignored.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz sequence engine: FSM state encoding
// and the status codes reported on completion.
package collatz_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] ST_OK   = 2'b00;  // sequence reached 1
    localparam logic [1:0] ST_ZERO = 2'b01;  // start value was 0
    localparam logic [1:0] ST_OVF  = 2'b10;  // 3n+1 did not fit in N_W bits
    localparam logic [1:0] ST_SAT  = 2'b11;  // step counter would wrap

endpackage

// File: rtl/collatz_seq_engine_if.sv
// Request/result bundle between a controller (master) and the Collatz
// engine (slave). The peak field exists only when COLLATZ_PEAK_EN is defined.
interface collatz_seq_engine_if #(
    parameter int N_W   = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [N_W-1:0]   n_in;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps;
    logic [1:0]       status;
`ifdef COLLATZ_PEAK_EN
    logic [N_W-1:0]   peak;

    modport master (output start, n_in, abort,
                    input  busy, done, steps, status, peak);
    modport slave  (input  start, n_in, abort,
                    output busy, done, steps, status, peak);
`else
    modport master (output start, n_in, abort,
                    input  busy, done, steps, status);
    modport slave  (input  start, n_in, abort,
                    output busy, done, steps, status);
`endif
endinterface

// File: rtl/collatz_step.sv
// One Collatz iteration: n/2 for even n, 3n+1 for odd n. The odd case is
// evaluated two bits wider than n so the overflow flag is exact.
module collatz_step #(
    parameter int N_W = 16
) (
    input  logic [N_W-1:0] i_n,
    output logic [N_W-1:0] o_next,
    output logic           o_ovf
);
    logic [N_W+1:0] w_triple;

    // 3n+1 as n + 2n + 1; max value 3*2^N_W - 2 fits in N_W+2 bits
    assign w_triple = {2'b00, i_n} + {1'b0, i_n, 1'b0} + (N_W+2)'(1);

    // Select halving or 3n+1; overflow is only meaningful on the odd path
    always_comb begin
        o_next = i_n >> 1;
        o_ovf  = 1'b0;
        if (i_n[0]) begin
            o_next = w_triple[N_W-1:0];
            o_ovf  = |w_triple[N_W+1:N_W];
        end
    end
endmodule

// File: rtl/collatz_seq_engine.sv
// Collatz sequence engine: counts iterations from a start value down to 1,
// one iteration per clock. Optional peak tracking under COLLATZ_PEAK_EN.
// busy/done are registered copies of the state, so they lag it by one cycle.
module collatz_seq_engine
    import collatz_pkg::*;
#(
    parameter int N_W   = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    collatz_seq_engine_if.slave  bus
);
    state_t           r_state;
    logic [N_W-1:0]   r_n;
    logic [CNT_W-1:0] r_steps;
    logic [1:0]       r_status;
    logic             r_busy;
    logic             r_done;
`ifdef COLLATZ_PEAK_EN
    logic [N_W-1:0]   r_peak;
`endif

    logic [N_W-1:0]   w_next;
    logic             w_ovf;

    collatz_step #(.N_W(N_W)) u_step (
        .i_n    (r_n),
        .o_next (w_next),
        .o_ovf  (w_ovf)
    );

    // Control FSM with datapath registers; reset > abort > start/step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_steps  <= '0;
            r_status <= ST_OK;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef COLLATZ_PEAK_EN
            r_peak   <= '0;
`endif
        end else begin
            r_busy <= (r_state == S_RUN);
            r_done <= (r_state == S_DONE);
            if (bus.abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            r_n      <= bus.n_in;
                            r_steps  <= '0;
                            r_status <= ST_OK;
`ifdef COLLATZ_PEAK_EN
                            r_peak   <= bus.n_in;
`endif
                            r_state  <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (r_n == '0) begin
                            r_status <= ST_ZERO;
                            r_steps  <= '0;
                            r_state  <= S_DONE;
                        end else if (r_n == N_W'(1)) begin
                            r_state  <= S_DONE;
                        end else if (w_ovf) begin
                            r_status <= ST_OVF;
                            r_state  <= S_DONE;
                        end else if (&r_steps) begin
                            r_status <= ST_SAT;
                            r_state  <= S_DONE;
                        end else begin
                            r_n     <= w_next;
                            r_steps <= r_steps + CNT_W'(1);
`ifdef COLLATZ_PEAK_EN
                            if (w_next > r_peak) r_peak <= w_next;
`endif
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.steps  = r_steps;
    assign bus.status = r_status;
`ifdef COLLATZ_PEAK_EN
    assign bus.peak   = r_peak;
`endif
endmodule

// File: tb/tb_collatz_seq_engine.sv
// Bench for collatz_seq_engine: three instances (16/8, 8/8, 16/4 widths),
// scoreboard of expected results, directed steps in one initial block.
// Peak checks are compiled in when COLLATZ_PEAK_EN is defined.
module tb_collatz_seq_engine;
    logic clk;
    logic rst_n;

    typedef struct {
        int          sel;
        int unsigned steps;
        int unsigned status;
        int unsigned peak;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    logic        start_a [3];
    logic [15:0] n_a     [3];
    logic        abort_a [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic [15:0] steps_a [3];
    logic [1:0]  status_a[3];
    logic [15:0] peak_a  [3];

    collatz_seq_engine_if #(.N_W(16), .CNT_W(8)) if_m ();
    collatz_seq_engine_if #(.N_W(8),  .CNT_W(8)) if_8 ();
    collatz_seq_engine_if #(.N_W(16), .CNT_W(4)) if_c ();

    collatz_seq_engine #(.N_W(16), .CNT_W(8)) u_main (.clk(clk), .rst_n(rst_n), .bus(if_m));
    collatz_seq_engine #(.N_W(8),  .CNT_W(8)) u_n8   (.clk(clk), .rst_n(rst_n), .bus(if_8));
    collatz_seq_engine #(.N_W(16), .CNT_W(4)) u_c4   (.clk(clk), .rst_n(rst_n), .bus(if_c));

    assign if_m.start = start_a[0];
    assign if_m.n_in  = n_a[0];
    assign if_m.abort = abort_a[0];
    assign if_8.start = start_a[1];
    assign if_8.n_in  = n_a[1][7:0];
    assign if_8.abort = abort_a[1];
    assign if_c.start = start_a[2];
    assign if_c.n_in  = n_a[2];
    assign if_c.abort = abort_a[2];

    assign busy_a[0]   = if_m.busy;
    assign busy_a[1]   = if_8.busy;
    assign busy_a[2]   = if_c.busy;
    assign done_a[0]   = if_m.done;
    assign done_a[1]   = if_8.done;
    assign done_a[2]   = if_c.done;
    assign steps_a[0]  = {8'b0, if_m.steps};
    assign steps_a[1]  = {8'b0, if_8.steps};
    assign steps_a[2]  = {12'b0, if_c.steps};
    assign status_a[0] = if_m.status;
    assign status_a[1] = if_8.status;
    assign status_a[2] = if_c.status;
`ifdef COLLATZ_PEAK_EN
    assign peak_a[0]   = if_m.peak;
    assign peak_a[1]   = {8'b0, if_8.peak};
    assign peak_a[2]   = if_c.peak;
`else
    assign peak_a[0]   = 16'd0;
    assign peak_a[1]   = 16'd0;
    assign peak_a[2]   = 16'd0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference Collatz walk with the engine's width limits
    function automatic void model(input int unsigned n, input int nw, input int cw,
                                  output int unsigned st, output int unsigned stat,
                                  output int unsigned pk);
        longint unsigned v    = longint'(n);
        longint unsigned lim  = 64'd1 << nw;
        int unsigned     cmax = (32'd1 << cw) - 1;
        longint unsigned nx;
        st = 0; stat = 0; pk = n;
        if (n == 0) begin stat = 1; return; end
        while (v != 1) begin
            nx = v[0] ? (3 * v + 1) : (v >> 1);
            if (nx >= lim) begin stat = 2; return; end
            if (st == cmax) begin stat = 3; return; end
            v = nx;
            st++;
            if (v > longint'(pk)) pk = int'(v);
        end
    endfunction

    // Drive one request, track completion, compare against the scoreboard.
    // glitch>0 pulses a second start (n=6) that cycle, which must be ignored.
    task automatic do_case(input int sel, input int unsigned n,
                           input int unsigned e_steps, input int unsigned e_status,
                           input int unsigned e_peak, input int glitch);
        exp_t e;
        int   cyc;
        bit   seen;
        e.sel = sel; e.steps = e_steps; e.status = e_status; e.peak = e_peak;
        sb.push_back(e);
        @(negedge clk);
        start_a[sel] = 1'b1;
        n_a[sel]     = 16'(n);
        @(posedge clk);
        #1;
        start_a[sel] = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 2000 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            start_a[sel] = 1'b0;
            if (cyc == 1) check($sformatf("busy_rise[%0d]", n), 32'(busy_a[sel]), 32'd1);
            if (glitch > 0 && cyc == glitch) begin
                start_a[sel] = 1'b1;
                n_a[sel]     = 16'd6;
            end
            if (done_a[sel] === 1'b1) seen = 1'b1;
        end
        start_a[sel] = 1'b0;
        check($sformatf("done_seen[%0d]", n), 32'(done_a[sel]), 32'd1);
        e = sb.pop_front();
        check($sformatf("latency[%0d]", n), 32'(cyc), 32'(e.steps + 2));
        check($sformatf("steps[%0d]", n),   32'(steps_a[e.sel]),  32'(e.steps));
        check($sformatf("status[%0d]", n),  32'(status_a[e.sel]), 32'(e.status));
        check($sformatf("busy_done[%0d]", n), 32'(busy_a[e.sel]), 32'd0);
`ifdef COLLATZ_PEAK_EN
        check($sformatf("peak[%0d]", n),    32'(peak_a[e.sel]),   32'(e.peak));
`endif
        $display("case sel=%0d n=%0d steps=%0d status=%0d cycles=%0d",
                 sel, n, steps_a[sel], status_a[sel], cyc);
    endtask

    initial begin
        int unsigned ms, mst, mpk, rn;
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0; n_a[i] = 16'd0; abort_a[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy_a[0]),   32'd0);
        check("rst_done",   32'(done_a[0]),   32'd0);
        check("rst_steps",  32'(steps_a[0]),  32'd0);
        check("rst_status", 32'(status_a[0]), 32'd0);
        check("rst_done_n8", 32'(done_a[1]),  32'd0);
`ifdef COLLATZ_PEAK_EN
        check("rst_peak",   32'(peak_a[0]),   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_case(0, 6, 8, 0, 16, 0);
        repeat (4) @(posedge clk);
        #1;
        check("hold_done",  32'(done_a[0]),  32'd1);
        check("hold_steps", 32'(steps_a[0]), 32'd8);
        $display("hold done=%0d steps=%0d", done_a[0], steps_a[0]);

        do_case(0, 27, 111, 0, 9232, 5);
        do_case(0, 1, 0, 0, 1, 0);
        do_case(0, 0, 0, 1, 0, 0);
        do_case(1, 27, 11, 2, 214, 0);
        do_case(2, 27, 15, 3, 484, 0);

        model(65535, 16, 8, ms, mst, mpk);
        do_case(0, 65535, ms, mst, mpk, 0);
        for (int k = 0; k < 3; k++) begin
            rn = $urandom_range(2, 3000);
            model(rn, 16, 8, ms, mst, mpk);
            do_case(0, rn, ms, mst, mpk, 0);
        end

        // abort mid-run together with start: abort wins, counters keep values
        @(negedge clk);
        start_a[0] = 1'b1; n_a[0] = 16'd27;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort_a[0] = 1'b1; start_a[0] = 1'b1; n_a[0] = 16'd6;
        @(posedge clk);
        #1;
        abort_a[0] = 1'b0; start_a[0] = 1'b0;
        check("abort_steps",  32'(steps_a[0]),  32'd9);
        check("abort_status", 32'(status_a[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", 32'(busy_a[0]), 32'd0);
        check("abort_done", 32'(done_a[0]), 32'd0);
        check("abort_hold_steps", 32'(steps_a[0]), 32'd9);
        $display("abort busy=%0d done=%0d steps=%0d", busy_a[0], done_a[0], steps_a[0]);

        // reset pulse in the middle of a run
        @(negedge clk);
        start_a[0] = 1'b1; n_a[0] = 16'd27;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy",   32'(busy_a[0]),   32'd0);
        check("mrst_done",   32'(done_a[0]),   32'd0);
        check("mrst_steps",  32'(steps_a[0]),  32'd0);
        check("mrst_status", 32'(status_a[0]), 32'd0);
`ifdef COLLATZ_PEAK_EN
        check("mrst_peak",   32'(peak_a[0]),   32'd0);
`endif
        $display("midrun reset busy=%0d done=%0d steps=%0d", busy_a[0], done_a[0], steps_a[0]);
        @(negedge clk);
        rst_n = 1'b1;

        do_case(0, 6, 8, 0, 16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
